// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and constants (receiver/transmitter).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_COMP_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_RECEIVE = 3'd2,
        ST_STOP    = 3'd3,
        ST_RESYNC  = 3'd4
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver_if
//  Description : Byte hand-off and error-flag bundle between receiver and consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_receiver_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ack;
    logic                   err_clr;
    logic                   frame_err;
    logic                   overrun_err;

    modport master (
        output rx_data, rx_valid, frame_err, overrun_err,
        input  rx_ack, err_clr
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun_err,
        output rx_ack, err_clr
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Generic two-flop synchronizer, async active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  wire  clk,
    input  wire  resetn,
    input  wire  i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 serial receiver with valid/ack hold register and sticky errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
(
    input  wire                    clk,
    input  wire                    resetn,
    input  wire  [UART_COMP_W-1:0] comp,
    input  wire                    rec_en,
    input  wire                    uart_rx,
    uart_receiver_if.master        rx_if
);

    logic                   w_rx_s;
    uart_rx_state_t         r_state;
    logic [UART_COMP_W-1:0] r_comp_int;
    logic [UART_COMP_W-1:0] r_comp_c;
    logic [3:0]             r_bit_c;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun_err;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (uart_rx),
        .o_q    (w_rx_s)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_comp_int    <= '0;
            r_comp_c      <= '0;
            r_bit_c       <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else if (!rec_en) begin
            r_state       <= ST_IDLE;
            r_comp_int    <= '0;
            r_comp_c      <= '0;
            r_bit_c       <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            // Clears come first so an error set later in this cycle wins.
            if (rx_if.err_clr) begin
                r_frame_err   <= 1'b0;
                r_overrun_err <= 1'b0;
            end
            if (rx_if.rx_ack && r_rx_valid) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state    <= ST_START;
                        r_comp_int <= comp;
                        r_comp_c   <= '0;
                    end
                end
                ST_START: begin
                    if (r_comp_c >= (r_comp_int >> 1)) begin
                        r_comp_c <= '0;
                        r_state  <= w_rx_s ? ST_IDLE : ST_RECEIVE;
                    end else begin
                        r_comp_c <= r_comp_c + 16'd1;
                    end
                end
                ST_RECEIVE: begin
                    if (r_comp_c >= r_comp_int) begin
                        r_comp_c <= '0;
                        r_shift  <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_c == 4'd7) begin
                            r_bit_c <= '0;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_c <= r_bit_c + 4'd1;
                        end
                    end else begin
                        r_comp_c <= r_comp_c + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_comp_c >= r_comp_int) begin
                        r_comp_c <= '0;
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                            if (!r_rx_valid || rx_if.rx_ack) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun_err <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_RESYNC;
                        end
                    end else begin
                        r_comp_c <= r_comp_c + 16'd1;
                    end
                end
                // A held-low line (break) must not look like a fresh start bit.
                ST_RESYNC: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_if.rx_data     = r_rx_data;
    assign rx_if.rx_valid    = r_rx_valid;
    assign rx_if.frame_err   = r_frame_err;
    assign rx_if.overrun_err = r_overrun_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Directed frame-level bench for uart_receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int COMP = 15;
    localparam int P    = COMP + 1;
    localparam int H    = COMP >> 1;
    // Line cycle whose following edge performs the stop sample:
    // 2 sync flops + 1 IDLE detect edge, then START/RECEIVE/STOP counting.
    localparam int ACK_CYC = 3 + H + 9 * P;
    localparam int EN_CYC  = 5 * P + 8;

    logic        clk;
    logic        resetn;
    logic [15:0] comp;
    logic        rec_en;
    logic        uart_rx;

    int n_checks;
    int n_fail;

    uart_receiver_if u_if ();

    uart_receiver dut (
        .clk     (clk),
        .resetn  (resetn),
        .comp    (comp),
        .rec_en  (rec_en),
        .uart_rx (uart_rx),
        .rx_if   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         send;
        logic [7:0] data;
        bit         ack;
        bit         clr;
        logic [7:0] e_data;
        bit         e_valid;
        bit         e_ferr;
        bit         e_oerr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input bit v,
                           input bit f, input bit o);
        chk(tag, "rx_data",     32'(u_if.rx_data),     32'(d));
        chk(tag, "rx_valid",    32'(u_if.rx_valid),    32'(v));
        chk(tag, "frame_err",   32'(u_if.frame_err),   32'(f));
        chk(tag, "overrun_err", 32'(u_if.overrun_err), 32'(o));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        u_if.rx_ack = 1'b1;
        idle(1);
        u_if.rx_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        u_if.err_clr = 1'b1;
        idle(1);
        u_if.err_clr = 1'b0;
    endtask

    // Drives start + 8 data (LSB first) + stop; line is left at the stop value.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int ack_cyc, input int en_cyc);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        for (int c = 0; c < 10 * P; c++) begin
            uart_rx     = bits[c / P];
            u_if.rx_ack = (c == ack_cyc);
            rec_en      = (c != en_cyc);
            @(posedge clk);
            #1;
        end
        u_if.rx_ack = 1'b0;
        rec_en      = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        resetn       = 1'b0;
        comp         = 16'(COMP);
        rec_en       = 1'b1;
        uart_rx      = 1'b1;
        u_if.rx_ack  = 1'b0;
        u_if.err_clr = 1'b0;

        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};

        idle(3);
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        idle(5);
        chk_out("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].ack) pulse_ack();
            if (vecs[i].clr) pulse_clr();
            if (vecs[i].send) send_frame(vecs[i].data, 1'b1, -1, -1);
            idle(2);
            chk_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                    vecs[i].e_ferr, vecs[i].e_oerr);
        end

        // Short low glitch must abort in START without any flag change.
        pulse_ack();
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(40);
        chk_out("glitch", 8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, -1, -1);
        idle(2);
        chk_out("after_glitch", 8'h5A, 1'b1, 1'b0, 1'b0);

        // Low stop bit, then a 100-cycle break, then a clean frame.
        pulse_ack();
        send_frame(8'h55, 1'b0, -1, -1);
        idle(100);
        chk_out("frame_err", 8'h5A, 1'b0, 1'b1, 1'b0);
        uart_rx = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1, -1, -1);
        idle(2);
        chk_out("after_break", 8'h81, 1'b1, 1'b1, 1'b0);
        pulse_clr();
        chk_out("err_clr", 8'h81, 1'b1, 1'b0, 1'b0);

        // Ack coincident with the stop sample of the next byte.
        pulse_ack();
        send_frame(8'h66, 1'b1, -1, -1);
        idle(2);
        chk_out("pend66", 8'h66, 1'b1, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, ACK_CYC, -1);
        idle(2);
        chk_out("ack_same_cycle", 8'h77, 1'b1, 1'b0, 1'b0);

        // Build an overrun, then drop rec_en for one cycle during bit 4.
        send_frame(8'h44, 1'b1, -1, -1);
        idle(2);
        chk_out("overrun44", 8'h77, 1'b1, 1'b0, 1'b1);
        send_frame(8'hF3, 1'b1, -1, EN_CYC);
        idle(2);
        chk_out("rec_en_clear", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, -1, -1);
        idle(2);
        chk_out("after_rec_en", 8'hC3, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a frame.
        uart_rx = 1'b0;
        idle(30);
        #2;
        resetn = 1'b0;
        #1;
        chk_out("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        idle(2);
        uart_rx = 1'b1;
        idle(3);
        resetn = 1'b1;
        idle(5);
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(2);
        chk_out("after_reset", 8'h3C, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
